// File: rtl/extensor_imediato_pipe.sv
// Registered immediate generator between decode and the execute operand mux.
// Valid/ready handshake with a two-entry skid buffer and an illegal-mode counter.
module extensor_imediato_pipe #(
    parameter int DATA_W = 32,
    parameter int IN_W   = 18,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] instrucao,
    input  logic [IN_W-1:0]   valor,
    input  logic [2:0]        ext,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] imediato,
    output logic              ext_invalido,
    output logic [CNT_W-1:0]  cont_invalido
);

    typedef enum logic [1:0] {VAZIO, UM, CHEIO} estado_t;

    estado_t           estado;
    logic [DATA_W-1:0] imm_calc;
    logic              inv_calc;
    logic [DATA_W-1:0] skid_imm;
    logic              skid_inv;
    logic              accept;
    logic              emit;
    logic              unused_bits;

    // Only bits [25:0] of the instruction word feed any mode.
    assign unused_bits = &{1'b0, instrucao[DATA_W-1:26]};

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        imm_calc = '0;
        inv_calc = 1'b0;
        case (ext)
            3'b000:  imm_calc = DATA_W'($signed(instrucao[15:0]));
            3'b001:  imm_calc = DATA_W'($signed(instrucao[25:0]));
            3'b010:  imm_calc = DATA_W'($signed(valor));
            3'b011:  imm_calc = DATA_W'(instrucao[15:0]);
            3'b100:  imm_calc = DATA_W'(instrucao[15:0]) << 16;
            3'b101:  imm_calc = DATA_W'($signed(instrucao[15:0])) << 2;
            default: inv_calc = 1'b1;
        endcase
    end

    // Ready depends only on registered state, never on out_ready.
    assign in_ready  = (estado != CHEIO) && rst_n;
    assign out_valid = (estado != VAZIO);
    assign accept    = in_valid && in_ready;
    assign emit      = out_valid && out_ready;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the data registers are cleared too, so a dropped entry can never reappear.
            estado        <= VAZIO;
            imediato      <= '0;
            ext_invalido  <= 1'b0;
            skid_imm      <= '0;
            skid_inv      <= 1'b0;
            cont_invalido <= '0;
        end else begin
            if (accept && inv_calc && (cont_invalido != {CNT_W{1'b1}}))
                cont_invalido <= cont_invalido + 1'b1;

            case (estado)
                VAZIO: begin
                    if (accept) begin
                        imediato     <= imm_calc;
                        ext_invalido <= inv_calc;
                        estado       <= UM;
                    end
                end
                UM: begin
                    if (accept && emit) begin
                        imediato     <= imm_calc;
                        ext_invalido <= inv_calc;
                    end else if (accept) begin
                        skid_imm <= imm_calc;
                        skid_inv <= inv_calc;
                        estado   <= CHEIO;
                    end else if (emit) begin
                        estado <= VAZIO;
                    end
                end
                CHEIO: begin
                    if (emit) begin
                        imediato     <= skid_imm;
                        ext_invalido <= skid_inv;
                        estado       <= UM;
                    end
                end
                default: estado <= VAZIO;
            endcase
        end
    end

endmodule

// File: tb/tb_extensor_imediato_pipe.sv
// Directed bench for extensor_imediato_pipe: mode table, backpressure,
// counter saturation (CNT_W=2) and reset while the skid buffer is full.
module tb_extensor_imediato_pipe;

    localparam int DATA_W = 32;
    localparam int IN_W   = 18;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] instrucao;
    logic [IN_W-1:0]   valor;
    logic [2:0]        ext;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] imediato;
    logic              ext_invalido;
    logic [CNT_W-1:0]  cont_invalido;

    int checks   = 0;
    int failures = 0;

    extensor_imediato_pipe #(.DATA_W(DATA_W), .IN_W(IN_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .instrucao     (instrucao),
        .valor         (valor),
        .ext           (ext),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .imediato      (imediato),
        .ext_invalido  (ext_invalido),
        .cont_invalido (cont_invalido)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]        ext;
        logic [DATA_W-1:0] instrucao;
        logic [IN_W-1:0]   valor;
        logic [DATA_W-1:0] exp_imm;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] e, input logic [DATA_W-1:0] ins, input logic [IN_W-1:0] val);
        in_valid  = v;
        ext       = e;
        instrucao = ins;
        valor     = val;
    endtask

    initial begin
        vecs[0]  = '{3'b000, 32'h0000_8001, 18'h0,     32'hFFFF_8001};
        vecs[1]  = '{3'b001, 32'h0200_0000, 18'h0,     32'hFE00_0000};
        vecs[2]  = '{3'b010, 32'h0,         18'h20000, 32'hFFFE_0000};
        vecs[3]  = '{3'b011, 32'h0000_8001, 18'h0,     32'h0000_8001};
        vecs[4]  = '{3'b100, 32'h0000_1234, 18'h0,     32'h1234_0000};
        vecs[5]  = '{3'b101, 32'h0000_FFFF, 18'h0,     32'hFFFF_FFFC};
        vecs[6]  = '{3'b000, 32'h0000_7FFF, 18'h0,     32'h0000_7FFF};
        vecs[7]  = '{3'b001, 32'h01FF_FFFF, 18'h0,     32'h01FF_FFFF};
        vecs[8]  = '{3'b010, 32'hFFFF_FFFF, 18'h1FFFF, 32'h0001_FFFF};
        vecs[9]  = '{3'b100, 32'hFFFF_ABCD, 18'h0,     32'hABCD_0000};
        vecs[10] = '{3'b101, 32'h0000_4000, 18'h0,     32'h0001_0000};
        vecs[11] = '{3'b011, 32'hFFFF_FFFF, 18'h3FFFF, 32'h0000_FFFF};

        // Reset state
        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 3'b000, '0, '0);
        tick();
        tick();
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd0);
        check("reset_imediato", 64'(imediato), 64'd0);
        check("reset_cont", 64'(cont_invalido), 64'd0);
        rst_n = 1'b1;
        #1;
        check("release_in_ready", 64'(in_ready), 64'd1);

        // Mode table at full throughput, one accept per cycle
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, vecs[i].ext, vecs[i].instrucao, vecs[i].valor);
            tick();
            check($sformatf("vec%0d_imediato", i), 64'(imediato), 64'(vecs[i].exp_imm));
            check($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("vec%0d_invalido", i), 64'(ext_invalido), 64'd0);
        end
        check("table_cont", 64'(cont_invalido), 64'd0);

        // Drain to empty
        drive(1'b0, 3'b000, '0, '0);
        tick();
        check("drain_out_valid", 64'(out_valid), 64'd0);

        // Backpressure: A then B fill both entries
        out_ready = 1'b0;
        drive(1'b1, 3'b000, 32'h0000_0001, '0);
        tick();
        check("bp_a_imediato", 64'(imediato), 64'h1);
        check("bp_a_in_ready", 64'(in_ready), 64'd1);
        drive(1'b1, 3'b000, 32'h0000_0002, '0);
        tick();
        check("bp_full_in_ready", 64'(in_ready), 64'd0);
        check("bp_full_imediato", 64'(imediato), 64'h1);
        // Offered while full: must not be taken
        drive(1'b1, 3'b000, 32'h0000_0003, '0);
        tick();
        check("bp_hold_imediato", 64'(imediato), 64'h1);
        check("bp_hold_out_valid", 64'(out_valid), 64'd1);
        check("bp_hold_in_ready", 64'(in_ready), 64'd0);
        drive(1'b0, 3'b000, '0, '0);
        out_ready = 1'b1;
        tick();
        check("bp_second_imediato", 64'(imediato), 64'h2);
        check("bp_second_out_valid", 64'(out_valid), 64'd1);
        tick();
        check("bp_empty_out_valid", 64'(out_valid), 64'd0);

        // Illegal modes: counter saturates at 3 for CNT_W=2
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, (i == 2) ? 3'b110 : 3'b111, 32'hFFFF_FFFF, 18'h3FFFF);
            tick();
            check($sformatf("inv%0d_cont", i), 64'(cont_invalido), (i < 3) ? 64'(i + 1) : 64'd3);
            check($sformatf("inv%0d_imediato", i), 64'(imediato), 64'd0);
            check($sformatf("inv%0d_flag", i), 64'(ext_invalido), 64'd1);
        end
        drive(1'b0, 3'b000, '0, '0);
        tick();
        check("inv_idle_cont", 64'(cont_invalido), 64'd3);

        // Reset while full
        out_ready = 1'b0;
        drive(1'b1, 3'b000, 32'h0000_00AA, '0);
        tick();
        drive(1'b1, 3'b000, 32'h0000_00BB, '0);
        tick();
        check("pre_reset_in_ready", 64'(in_ready), 64'd0);
        drive(1'b0, 3'b000, '0, '0);
        rst_n = 1'b0;
        tick();
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        check("midreset_imediato", 64'(imediato), 64'd0);
        check("midreset_cont", 64'(cont_invalido), 64'd0);
        check("midreset_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        #1;
        check("postreset_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        drive(1'b1, 3'b011, 32'h0000_8001, '0);
        tick();
        check("postreset_imediato", 64'(imediato), 64'h0000_8001);
        check("postreset_out_valid", 64'(out_valid), 64'd1);
        drive(1'b0, 3'b000, '0, '0);
        tick();
        check("postreset_empty", 64'(out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
